// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: per-register countdown scoreboard driving ID-stage stall and branch-flush controls.
//
// Ports:
//    clk, pc_reset                  pipeline clock; asynchronous active-high reset
//    issue_valid                    ID holds a real instruction
//    issue_rs/rt, issue_rs/rt_used  source registers and their read enables
//    issue_rd, issue_wr, issue_lat  destination, write enable, producer latency
//    branch_taken                   redirect resolved in EX this cycle
//    pc_write, if_id_write          PC / IF/ID load enables
//    controls_clear, if_id_flush    ID/EX bubble insert, IF/ID squash
//    busy_mask                      bit i set while register i has a pending result
//    stall_cycles, flush_cycles     saturating event counters (only with SCOREBOARD_STATS_EN)
//
// Optional feature macro: SCOREBOARD_STATS_EN
module pipe_hazard_scoreboard #(
   parameter int NUM_REGS     = 16,
   parameter int REG_ADDR_W   = 4,
   parameter int LAT_W        = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  pc_reset,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rs,
   input  logic [REG_ADDR_W-1:0] issue_rt,
   input  logic                  issue_rs_used,
   input  logic                  issue_rt_used,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_wr,
   input  logic [LAT_W-1:0]      issue_lat,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  controls_clear,
   output logic                  if_id_flush,
   output logic [NUM_REGS-1:0]   busy_mask
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [15:0]           stall_cycles,
   output logic [15:0]           flush_cycles
`endif
);
   logic [LAT_W-1:0] cnt [NUM_REGS];
   logic [3:0]       flush_cnt;
   logic             hit_rs, hit_rt, flushing, stall, accept;

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < NUM_REGS; i++) busy_mask[i] = cnt[i] != '0;
   end

   assign hit_rs   = issue_rs_used & (issue_rs != '0) & busy_mask[issue_rs];
   assign hit_rt   = issue_rt_used & (issue_rt != '0) & busy_mask[issue_rt];
   assign flushing = branch_taken | (flush_cnt != '0);
   // A flush squashes the ID instruction, so it must not also hold the PC.
   assign stall    = issue_valid & (hit_rs | hit_rt) & !flushing;
   assign accept   = issue_valid & !stall & !flushing;

   // Reset forces all enables/clears high so the pipeline comes up flushed.
   assign pc_write       = pc_reset | !stall;
   assign if_id_write    = pc_reset | !stall;
   assign controls_clear = pc_reset | stall | flushing;
   assign if_id_flush    = pc_reset | flushing;

   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
         flush_cnt <= '0;
      end else begin
         // cnt[0] is never set, so the zero register stays untracked.
         for (int i = 0; i < NUM_REGS; i++)
            cnt[i] <= (accept & issue_wr & (issue_rd != '0) & (issue_rd == REG_ADDR_W'(i))) ? issue_lat :
                      (cnt[i] != '0) ? cnt[i] - LAT_W'(1) : cnt[i];
         flush_cnt <= branch_taken ? 4'(FLUSH_CYCLES - 1) :
                      (flush_cnt != '0) ? flush_cnt - 4'd1 : flush_cnt;
      end
   end

`ifdef SCOREBOARD_STATS_EN
   always_ff @(posedge clk or posedge pc_reset) begin
      if (pc_reset) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         stall_cycles <= stall_cycles + 16'(stall & (stall_cycles != 16'hFFFF));
         flush_cycles <= flush_cycles + 16'(flushing & (flush_cycles != 16'hFFFF));
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed and random stimulus checked against a cycle-number reference model.
module tb_pipe_hazard_scoreboard;
   localparam int NR = 16;
   localparam int FC = 2;

   logic        clk = 1'b0, pc_reset = 1'b1;
   logic        issue_valid = 1'b0, issue_rs_used = 1'b0, issue_rt_used = 1'b0, issue_wr = 1'b0, branch_taken = 1'b0;
   logic [3:0]  issue_rs = '0, issue_rt = '0, issue_rd = '0;
   logic [2:0]  issue_lat = '0;
   logic        pc_write, if_id_write, controls_clear, if_id_flush;
   logic [15:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
   logic [15:0] stall_cycles, flush_cycles;
   int          m_stall = 0, m_flush = 0;
`endif

   always #5 clk = ~clk;

   pipe_hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(4), .LAT_W(3), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .pc_reset(pc_reset), .issue_valid(issue_valid),
      .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
      .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_lat(issue_lat), .branch_taken(branch_taken),
      .pc_write(pc_write), .if_id_write(if_id_write), .controls_clear(controls_clear),
      .if_id_flush(if_id_flush), .busy_mask(busy_mask)
`ifdef SCOREBOARD_STATS_EN
      , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
   );

   int errors = 0, checks = 0;
   int cyc = 0;
   int ready_at [NR];   // first cycle in which register r no longer blocks a reader
   int flush_until = 0; // first cycle after a branch shadow ends

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR; r++) ready_at[r] = 0;
      flush_until = 0;
`ifdef SCOREBOARD_STATS_EN
      m_stall = 0;
      m_flush = 0;
`endif
   endtask

   task automatic step(input logic v, input logic [3:0] rs, input logic rsu, input logic [3:0] rt, input logic rtu,
                       input logic [3:0] rd, input logic wr, input logic [2:0] lat, input logic br);
      logic hs, ht, fl, st, acc;
      logic [15:0] bm;
      issue_valid = v; issue_rs = rs; issue_rs_used = rsu; issue_rt = rt; issue_rt_used = rtu;
      issue_rd = rd; issue_wr = wr; issue_lat = lat; branch_taken = br;
      @(negedge clk);
      bm = '0;
      for (int r = 1; r < NR; r++) bm[r] = cyc < ready_at[r];
      hs  = rsu && rs != 0 && cyc < ready_at[rs];
      ht  = rtu && rt != 0 && cyc < ready_at[rt];
      fl  = br || cyc < flush_until;
      st  = v && (hs || ht) && !fl;
      acc = v && !st && !fl;
      chk("busy_mask", 32'(busy_mask), 32'(bm));
      chk("pc_write", 32'(pc_write), 32'(!st));
      chk("if_id_write", 32'(if_id_write), 32'(!st));
      chk("controls_clear", 32'(controls_clear), 32'(st || fl));
      chk("if_id_flush", 32'(if_id_flush), 32'(fl));
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_cycles", 32'(flush_cycles), 32'(m_flush));
      m_stall += int'(st);
      m_flush += int'(fl);
`endif
      @(posedge clk);
      if (acc && wr && rd != 0) ready_at[rd] = cyc + int'(lat) + 1;
      if (br) flush_until = cyc + FC;
      cyc++;
      #1;
   endtask

   initial begin
      model_reset();
      // Reset phase: outputs forced high, scoreboard empty.
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_mask), 32'h0);
      chk("rst_pc_write", 32'(pc_write), 32'h1);
      chk("rst_if_id_write", 32'(if_id_write), 32'h1);
      chk("rst_controls_clear", 32'(controls_clear), 32'h1);
      chk("rst_if_id_flush", 32'(if_id_flush), 32'h1);
      #2 pc_reset = 1'b0;

      // Load-use with latency 1.
      step(1, 0, 0, 0, 0, 3, 1, 1, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      // Latency 0 never stalls.
      step(1, 0, 0, 0, 0, 6, 1, 0, 0);
      step(1, 6, 1, 6, 1, 0, 0, 0, 0);
      // Long latency: 7 stall cycles then accept.
      step(1, 0, 0, 0, 0, 5, 1, 7, 0);
      repeat (8) step(1, 0, 0, 5, 1, 0, 0, 0, 0);
      // Re-issue to r5 mid-countdown: the set wins.
      step(1, 0, 0, 0, 0, 5, 1, 7, 0);
      step(1, 0, 0, 5, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1, 2, 0);
      repeat (3) step(1, 5, 1, 0, 0, 0, 0, 0, 0);
      // Zero register is never tracked.
      step(1, 0, 0, 0, 0, 0, 1, 7, 0);
      step(1, 0, 1, 0, 1, 0, 0, 0, 0);
      // Branch overrides a stall on r4; squashed instruction does not write.
      step(1, 0, 0, 0, 0, 4, 1, 3, 0);
      step(1, 4, 1, 0, 0, 9, 1, 7, 1);
      repeat (4) step(1, 4, 1, 0, 0, 0, 0, 0, 0);
      // Branch reload during the flush shadow.
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (3) step(1, 0, 0, 0, 0, 2, 1, 1, 0);

      // Asynchronous reset mid-countdown on r7 (cnt[7] = 4).
      step(1, 0, 0, 0, 0, 7, 1, 7, 0);
      repeat (3) step(1, 7, 1, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_busy7", 32'(busy_mask[7]), 32'h1);
      issue_valid = 1'b1; issue_rs = 4'd7; issue_rs_used = 1'b1; issue_wr = 1'b0; branch_taken = 1'b0;
      #2 pc_reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy_mask), 32'h0);
      chk("arst_pc_write", 32'(pc_write), 32'h1);
      chk("arst_if_id_write", 32'(if_id_write), 32'h1);
      chk("arst_controls_clear", 32'(controls_clear), 32'h1);
      chk("arst_if_id_flush", 32'(if_id_flush), 32'h1);
`ifdef SCOREBOARD_STATS_EN
      chk("arst_stall_cycles", 32'(stall_cycles), 32'h0);
`endif
      #2 pc_reset = 1'b0;
      model_reset();
      step(1, 7, 1, 0, 0, 0, 0, 0, 0);

      // Random traffic concentrated on a few registers to provoke hazards.
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 7) != 0),
              4'($urandom_range(0, 5)), 1'($urandom), 4'($urandom_range(0, 5)), 1'($urandom),
              4'($urandom_range(0, 5)), 1'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 15) == 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard and flush controller for the next-generation pipelined core. It replaces the fixed load-use check and the one-shot branch flusher with a per-register countdown scoreboard, so execution units can have any latency from 0 to 2^LAT_W-1. It sits beside the ID stage and drives the PC-write, IF/ID-write, ID/EX control-clear and IF/ID-flush signals. Register 0 is the zero register and is never tracked.

## Interface
- NUM_REGS, 16, number of architectural registers
- REG_ADDR_W, 4, register address width; $clog2(NUM_REGS)
- LAT_W, 3, latency field width; max producer latency 7
- FLUSH_CYCLES, 2, IF/ID squash cycles per taken branch, range 1..15
- clk  in  1  pipeline clock, rising edge
- pc_reset  in  1  asynchronous active-high reset
- issue_valid  in  1  ID holds a real instruction
- issue_rs, issue_rt  in  REG_ADDR_W  source registers
- issue_rs_used, issue_rt_used  in  1  the source is read
- issue_rd  in  REG_ADDR_W  destination register
- issue_wr  in  1  the instruction writes issue_rd
- issue_lat  in  LAT_W  number of issue slots before the result can be forwarded
- branch_taken  in  1  redirect resolved in EX this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- controls_clear  out  1  zero ID/EX control fields (bubble)
- if_id_flush  out  1  load nop into IF/ID
- busy_mask  out  NUM_REGS  bit i set when cnt[i] != 0

## Operation
- State:
  - cnt[1..NUM_REGS-1], LAT_W bits each.
  - flush_cnt, 4 bits.
- Combinational signals:
  - hit_rs = issue_rs_used & (issue_rs != 0) & (cnt[issue_rs] != 0); hit_rt is defined the same way.
  - flushing = branch_taken | (flush_cnt != 0).
  - stall = issue_valid & (hit_rs | hit_rt) & !flushing.
  - accept = issue_valid & !stall & !flushing.
- Outputs:
  - pc_write = !stall.
  - if_id_write = !stall.
  - controls_clear = stall | flushing.
  - if_id_flush = flushing.
- Branch priority: a branch overrides a stall. The PC must load the target and the instruction in ID is squashed, never issued.
- Scoreboard update each clock, for every i:
  - If accept & issue_wr & issue_rd == i & i != 0: cnt[i] <= issue_lat.
  - Else if cnt[i] != 0: cnt[i] <= cnt[i] - 1.
  - A set wins over a decrement on the same register in the same cycle.
- Flush counter:
  - branch_taken: flush_cnt <= FLUSH_CYCLES - 1. This also reloads while a flush is already active.
  - Otherwise, if flush_cnt != 0: decrement.
- Squashed or stalled instructions never modify the scoreboard.
- Sources equal to 0 never stall.

## Timing
- All outputs are combinational from the current state and inputs. Zero-cycle decision, no registered outputs.
- Latency example: a producer accepted in cycle T with issue_lat = L stalls a dependent consumer in cycles T+1..T+L. The consumer is accepted in cycle T+L+1.
- With L = 0 there is no stall; the forwarding path covers it.
- A taken branch in cycle T asserts if_id_flush in cycles T..T+FLUSH_CYCLES-1.
- Reset, while pc_reset is high:
  - all cnt = 0, flush_cnt = 0, busy_mask = 0.
  - pc_write = 1, if_id_write = 1, controls_clear = 1, if_id_flush = 1 (forced).
- Deassertion: the first clock after pc_reset falls operates normally.
- Reset mid-stall or mid-flush clears everything immediately, asynchronously.

## Configuration
- SCOREBOARD_STATS_EN defined:
  - Adds outputs stall_cycles and flush_cycles, 16 bits each.
  - Each counts cycles with stall or flushing high, respectively.
  - Both saturate at 16'hFFFF and reset to 0 on pc_reset.
- SCOREBOARD_STATS_EN undefined:
  - Neither port nor its logic exists.
  - All other behaviour is identical.

## Test plan
- Load-use: accept rd=3, lat=1 in cycle T. In T+1 issue rs=3, rs_used=1 -> stall=1 in T+1 only (pc_write=0, controls_clear=1). Accepted in T+2. busy_mask=16'h0008 in T+1.
- Long latency: rd=5, lat=7, then a consumer with rt=5 -> 7 consecutive stall cycles, accepted on the 8th. Re-issue to rd=5 with lat=2 mid-countdown -> cnt[5]=2 (set wins).
- Zero register: rd=0, lat=7, issue_wr=1 -> busy_mask stays 0. A following rs=0 consumer never stalls.
- Branch over stall: consumer stalled on r4 while branch_taken=1 -> pc_write=1, if_id_flush=1, controls_clear=1. No scoreboard change. With FLUSH_CYCLES=2, if_id_flush is high exactly 2 cycles.
- Branch reload: branch_taken again in the second flush cycle -> if_id_flush stays high 2 more cycles (3 total).
- Async reset: assert pc_reset mid-countdown (cnt[7]=4) between clock edges -> busy_mask=0 immediately, all four control outputs = 1. After release, a consumer of r7 is accepted with no stall. With SCOREBOARD_STATS_EN, stall_cycles returns to 0.
